tmec_decode_control: RTL and testbench
======================================

Name: tmec_decode_control

Overview:
Sequencer for the parallel inversionless Berlekamp-Massey datapath used in binary BCH decoding.
- Accepts a full odd-syndrome set from the syndrome stage.
- Drives the datapath strobes (synpe, msmpe, snce, bsel) and builds the per-iteration shuffled syndrome window.
- Tracks the error-locator degree L.
- Hands the finished sigma off to the Chien search through a valid/ready handshake.

Parameters:
M, 4, Galois field width (GF(2^M)).
T, 3, correctable errors; legal range T >= 2.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
start  in  1  syndromes valid; sampled only in IDLE.
syn_all  in  M*(2T-1)  S_1..S_(2T-1); S_k at bits [(k-1)*M +: M]; captured on accepted start.
d_r_nonzero  in  1  datapath discrepancy nonzero.
busy  out  1  high from LOAD through DONE inclusive.
syn1  out  M  captured S_1, held stable while busy.
syn_shuffled  out  M*(2T-1)  per-iteration syndrome window to datapath.
synpe  out  1  datapath initialise strobe.
msmpe  out  1  discrepancy compute strobe.
snce  out  1  sigma/beta update strobe.
bsel  out  1  beta-from-sigma select; qualified by snce.
err_count  out  ceil(log2(T+1))  current locator degree L.
sigma_valid  out  1  sigma in datapath final.
sigma_ready  in  1  Chien stage accepts sigma.

Behaviour:
- Reset: state IDLE. All outputs 0: busy, synpe, msmpe, snce, bsel, sigma_valid, err_count, syn1, syn_shuffled. Iteration counter r and syndrome store cleared. Reset mid-operation aborts immediately; no strobe is asserted in the cycle after reset.
- States: IDLE, LOAD, CALC, UPDATE, DONE.
- IDLE: start=1 at an edge captures syn_all, loads r=1 and goes to LOAD.
- LOAD: exactly one cycle.
  - synpe=1.
  - L <= (S_1 != 0) ? 1 : 0.
  - Next state CALC.
- CALC: one cycle, msmpe=1. Datapath registers d_r at the closing edge. Next state UPDATE.
- UPDATE: one cycle, snce=1.
  - bsel = d_r_nonzero && (2L <= 2r). When bsel=1, L <= 2r+1-L.
  - If r == T-1, go to DONE. Otherwise r <= r+1 and go to CALC.
- DONE: sigma_valid=1 and busy=1 until an edge with sigma_ready=1, then IDLE. sigma_ready=1 on the first DONE cycle gives a one-cycle DONE.
- Strobe rules:
  - synpe, msmpe and snce are mutually exclusive, one-hot by state.
  - bsel is 0 whenever snce=0.
  - Never assert msmpe and snce in the same cycle.
- syn_shuffled during CALC/UPDATE of iteration r:
  - Slot i (0..T) = S_(2r-i+1), i.e. bits [i*M +: M].
  - Index j = 2r-i+1 outside 1..2T-1 gives 0.
  - Slots T+1..2T-2 are always 0.
  - In LOAD, DONE and IDLE the window holds the r=1 window, or 0 after reset.
  - Implement as a syndrome shift register advanced by two positions per UPDATE; no combinational mux tree on r.
- Latency: start sampled at edge k gives LOAD in cycle k+1 and first DONE in cycle k+2T. For T=3 that is cycle k+6.
- start while busy: ignored; no re-capture.
- err_count mirrors L and is stable from DONE entry until the next LOAD.
- L never exceeds T. A result with L > T cannot occur for legal inputs; the bench checks it.

Test Plan:
- Reset then idle, M=4, T=3: all outputs 0 for 10 cycles; start held 0 -> no strobes.
- All-zero syndromes, start pulse at edge 0:
  - Strobes synpe@1, msmpe@2, snce@3, msmpe@4, snce@5.
  - sigma_valid@6, bsel never 1, err_count=0.
  - Datapath sigma = 1.
- Single error at position 0 (all S_k=1): err_count=1, bsel never 1 (d_r=0 both iterations), sigma = 1+x up to scaling.
- Two errors at GF(16) positions 1 and 4, syndromes from the golden model:
  - bsel=1 exactly at the first UPDATE.
  - err_count=2.
  - syn_shuffled slots match S_(2r-i+1) each iteration.
- Backpressure: sigma_ready=0 for 5 cycles in DONE -> sigma_valid and err_count held. ready=1 -> IDLE next edge. A second start during DONE is ignored.
- Reset asserted during second CALC -> next cycle IDLE with all outputs 0. A subsequent start runs a full clean sequence with correct err_count.

Source files
------------

// File: rtl/tmec_decode_control.sv
// tmec_decode_control: sequencer for the inversionless Berlekamp-Massey datapath of a binary BCH decoder.
// Captures the syndromes, steps the datapath strobes, tracks locator degree L and hands sigma to Chien.
module tmec_decode_control #(
    parameter int M = 4,
    parameter int T = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [M*(2*T-1)-1:0]       syn_all,
    input  logic                       d_r_nonzero,
    output logic                       busy,
    output logic [M-1:0]               syn1,
    output logic [M*(2*T-1)-1:0]       syn_shuffled,
    output logic                       synpe,
    output logic                       msmpe,
    output logic                       snce,
    output logic                       bsel,
    output logic [$clog2(T+1)-1:0]     err_count,
    output logic                       sigma_valid,
    input  logic                       sigma_ready
);
    localparam int W  = M*(2*T-1);
    localparam int H  = M*(3*T-3);
    localparam int EW = $clog2(T+1);

    typedef enum logic [2:0] {IDLE, LOAD, CALC, UPDATE, DONE} state_t;

    state_t        state_q;
    logic [W-1:0]  syn_q;
    logic [H-1:0]  win_q;
    logic [EW-1:0] r_q, l_q;
    logic [EW:0]   l_flip;

    // Slot k holds S_(2T-1-k); the r window sits at slots 2T-4..3T-4 and slides up two slots per iteration.
    function automatic logic [H-1:0] reorder(input logic [W-1:0] v);
        reorder = '0;
        for (int n = 0; n <= 2*T-2; n++) reorder[n*M +: M] = v[(2*T-2-n)*M +: M];
    endfunction

    assign busy        = state_q != IDLE;
    assign synpe       = state_q == LOAD;
    assign msmpe       = state_q == CALC;
    assign snce        = state_q == UPDATE;
    assign sigma_valid = state_q == DONE;
    assign bsel        = snce && d_r_nonzero && (l_q <= r_q);
    assign l_flip      = {r_q, 1'b1} - {1'b0, l_q};
    assign err_count   = l_q;
    assign syn1        = syn_q[M-1:0];

    always_comb begin
        syn_shuffled = '0;
        syn_shuffled[M*(T+1)-1:0] = win_q[M*(2*T-4) +: M*(T+1)];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            syn_q   <= '0;
            win_q   <= '0;
            r_q     <= '0;
            l_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q <= LOAD;
                    syn_q   <= syn_all;
                    win_q   <= reorder(syn_all);
                    r_q     <= EW'(1);
                end
                LOAD: begin
                    l_q     <= EW'(syn_q[M-1:0] != '0);
                    state_q <= CALC;
                end
                CALC: state_q <= UPDATE;
                UPDATE: begin
                    if (bsel) l_q <= l_flip[EW-1:0];
                    if (r_q == EW'(T-1)) begin
                        state_q <= DONE;
                        win_q   <= reorder(syn_q);
                    end else begin
                        state_q <= CALC;
                        r_q     <= r_q + EW'(1);
                        win_q   <= win_q << (2*M);
                    end
                end
                DONE: if (sigma_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tmec_decode_control.sv
// tb_tmec_decode_control: directed checks of strobe timing, syndrome window, locator degree and handshake.
module tb_tmec_decode_control;
    localparam int M  = 4;
    localparam int T  = 3;
    localparam int W  = M*(2*T-1);
    localparam int EW = $clog2(T+1);

    logic          clk = 0;
    logic          reset, start, d_r_nonzero, sigma_ready;
    logic [W-1:0]  syn_all, syn_shuffled;
    logic [M-1:0]  syn1;
    logic          busy, synpe, msmpe, snce, bsel, sigma_valid;
    logic [EW-1:0] err_count;
    logic [M-1:0]  s [1:2*T-1];
    int            checks = 0, fails = 0;

    tmec_decode_control #(.M(M), .T(T)) dut (
        .clk(clk), .reset(reset), .start(start), .syn_all(syn_all), .d_r_nonzero(d_r_nonzero),
        .busy(busy), .syn1(syn1), .syn_shuffled(syn_shuffled), .synpe(synpe), .msmpe(msmpe),
        .snce(snce), .bsel(bsel), .err_count(err_count), .sigma_valid(sigma_valid),
        .sigma_ready(sigma_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] exp_win(input int r);
        int j;
        exp_win = '0;
        for (int i = 0; i <= T; i++) begin
            j = 2*r - i + 1;
            if (j >= 1 && j <= 2*T-1) exp_win[i*M +: M] = s[j];
        end
    endfunction

    task automatic do_start;
        for (int k = 1; k <= 2*T-1; k++) syn_all[(k-1)*M +: M] = s[k];
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic test_reset;
        reset = 1; start = 0; d_r_nonzero = 0; sigma_ready = 1; syn_all = '1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({busy, synpe, msmpe, snce, bsel, sigma_valid, err_count, syn1, syn_shuffled} !== '0) begin
                fails++;
                $display("FAIL reset_idle c=%0d got busy=%b synpe=%b msmpe=%b snce=%b bsel=%b sv=%b err=%0d syn1=%h win=%h want all 0",
                         c, busy, synpe, msmpe, snce, bsel, sigma_valid, err_count, syn1, syn_shuffled);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_zero;
        logic [7:0] dp = 8'b0100_0010, bp = 8'b0;
        logic [5:0] ex;
        for (int k = 1; k <= 2*T-1; k++) s[k] = '0;
        d_r_nonzero = 0;
        do_start;
        for (int c = 1; c <= 2*T; c++) begin
            d_r_nonzero = dp[c];
            #1;
            ex = {1'b1, c == 1, c%2 == 0 && c < 2*T, c%2 == 1 && c > 1 && c < 2*T, bp[c], c == 2*T};
            checks++;
            if ({busy, synpe, msmpe, snce, bsel, sigma_valid} !== ex) begin
                fails++;
                $display("FAIL zero_strobes c=%0d got %b want %b", c, {busy, synpe, msmpe, snce, bsel, sigma_valid}, ex);
            end
            checks++;
            if (syn_shuffled !== exp_win((c < 2 || c == 2*T) ? 1 : c/2)) begin
                fails++;
                $display("FAIL zero_window c=%0d got %h want %h", c, syn_shuffled, exp_win((c < 2 || c == 2*T) ? 1 : c/2));
            end
            @(posedge clk); #1;
        end
        d_r_nonzero = 0;
        checks++;
        if ({busy, sigma_valid, err_count} !== {2'b00, EW'(0)}) begin
            fails++;
            $display("FAIL zero_idle got busy=%b sv=%b err=%0d want 0 0 0", busy, sigma_valid, err_count);
        end
    endtask

    task automatic test_single;
        logic [5:0] ex;
        for (int k = 1; k <= 2*T-1; k++) s[k] = 4'h1;
        d_r_nonzero = 0;
        do_start;
        for (int c = 1; c <= 2*T; c++) begin
            #1;
            ex = {1'b1, c == 1, c%2 == 0 && c < 2*T, c%2 == 1 && c > 1 && c < 2*T, 1'b0, c == 2*T};
            checks++;
            if ({busy, synpe, msmpe, snce, bsel, sigma_valid} !== ex) begin
                fails++;
                $display("FAIL single_strobes c=%0d got %b want %b", c, {busy, synpe, msmpe, snce, bsel, sigma_valid}, ex);
            end
            if (c == 2*T) begin
                checks++;
                if (err_count !== EW'(1)) begin
                    fails++;
                    $display("FAIL single_err got %0d want 1", err_count);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if ({busy, sigma_valid, err_count, syn1} !== {2'b00, EW'(1), 4'h1}) begin
            fails++;
            $display("FAIL single_idle got busy=%b sv=%b err=%0d syn1=%h want 0 0 1 1", busy, sigma_valid, err_count, syn1);
        end
    endtask

    task automatic test_two_errors;
        logic [7:0] dp = 8'b0001_1100, bp = 8'b0000_1000;
        int ep [0:6] = '{0, 0, 1, 0, 2, 0, 2};
        logic [5:0] ex;
        // alpha^1 + alpha^4 in GF(16), x^4+x+1: S1=1 S2=1 S3=7 S4=1 S5=0
        s[1] = 4'h1; s[2] = 4'h1; s[3] = 4'h7; s[4] = 4'h1; s[5] = 4'h0;
        d_r_nonzero = 0;
        do_start;
        for (int c = 1; c <= 2*T; c++) begin
            d_r_nonzero = dp[c];
            #1;
            ex = {1'b1, c == 1, c%2 == 0 && c < 2*T, c%2 == 1 && c > 1 && c < 2*T, bp[c], c == 2*T};
            checks++;
            if ({busy, synpe, msmpe, snce, bsel, sigma_valid} !== ex) begin
                fails++;
                $display("FAIL two_strobes c=%0d got %b want %b", c, {busy, synpe, msmpe, snce, bsel, sigma_valid}, ex);
            end
            checks++;
            if (syn_shuffled !== exp_win((c < 2 || c == 2*T) ? 1 : c/2)) begin
                fails++;
                $display("FAIL two_window c=%0d got %h want %h", c, syn_shuffled, exp_win((c < 2 || c == 2*T) ? 1 : c/2));
            end
            if (c%2 == 0) begin
                checks++;
                if (err_count !== EW'(ep[c])) begin
                    fails++;
                    $display("FAIL two_err c=%0d got %0d want %0d", c, err_count, ep[c]);
                end
            end
            checks++;
            if (syn1 !== 4'h1) begin
                fails++;
                $display("FAIL two_syn1 c=%0d got %h want 1", c, syn1);
            end
            @(posedge clk); #1;
        end
        d_r_nonzero = 0;
        checks++;
        if ({busy, sigma_valid, err_count} !== {2'b00, EW'(2)}) begin
            fails++;
            $display("FAIL two_idle got busy=%b sv=%b err=%0d want 0 0 2", busy, sigma_valid, err_count);
        end
    endtask

    task automatic test_backpressure;
        for (int k = 1; k <= 2*T-1; k++) s[k] = 4'h1;
        d_r_nonzero = 0;
        sigma_ready = 0;
        do_start;
        repeat (2*T-1) begin
            @(posedge clk); #1;
        end
        for (int k = 0; k < 5; k++) begin
            start = (k == 1);
            if (k == 1) syn_all = '0;
            #1;
            checks++;
            if ({busy, sigma_valid, synpe, err_count, syn1} !== {3'b110, EW'(1), 4'h1}) begin
                fails++;
                $display("FAIL bp_hold k=%0d got busy=%b sv=%b synpe=%b err=%0d syn1=%h want 1 1 0 1 1",
                         k, busy, sigma_valid, synpe, err_count, syn1);
            end
            @(posedge clk); #1;
        end
        sigma_ready = 1;
        #1;
        checks++;
        if (sigma_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_ready_cycle got sv=%b want 1", sigma_valid);
        end
        @(posedge clk); #1;
        checks++;
        if ({busy, sigma_valid, err_count, syn1} !== {2'b00, EW'(1), 4'h1} || syn_shuffled !== exp_win(1)) begin
            fails++;
            $display("FAIL bp_release got busy=%b sv=%b err=%0d syn1=%h win=%h want 0 0 1 1 %h",
                     busy, sigma_valid, err_count, syn1, syn_shuffled, exp_win(1));
        end
        @(posedge clk); #1;
        checks++;
        if ({busy, synpe} !== 2'b00) begin
            fails++;
            $display("FAIL bp_no_restart got busy=%b synpe=%b want 0 0", busy, synpe);
        end
    endtask

    task automatic test_reset_mid;
        s[1] = 4'h1; s[2] = 4'h1; s[3] = 4'h7; s[4] = 4'h1; s[5] = 4'h0;
        d_r_nonzero = 0;
        sigma_ready = 1;
        do_start;
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1;
        #1;
        checks++;
        if (msmpe !== 1'b1) begin
            fails++;
            $display("FAIL rmid_in_calc got msmpe=%b want 1", msmpe);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({busy, synpe, msmpe, snce, bsel, sigma_valid, err_count, syn1, syn_shuffled} !== '0) begin
                fails++;
                $display("FAIL rmid_zero k=%0d got busy=%b synpe=%b msmpe=%b snce=%b sv=%b err=%0d syn1=%h win=%h want all 0",
                         k, busy, synpe, msmpe, snce, sigma_valid, err_count, syn1, syn_shuffled);
            end
            reset = 0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset;
        test_zero;
        test_single;
        test_two_errors;
        test_backpressure;
        test_reset_mid;
        test_two_errors;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
